// File: rtl/ad_acq_sequencer.sv
// Burst acquisition sequencer: every acq_timing rising edge requests
// 2^SAMPLES_LOG2 conversions and emits their truncated average.
module ad_acq_sequencer #(
   parameter int DATA_WIDTH     = 16,
   parameter int SAMPLES_LOG2   = 3,
   parameter int TIMEOUT_CLOCKS = 200
) (
   input  logic                  clk_100M,
   input  logic                  rst,
   input  logic                  acq_timing,
   output logic                  conv_start,
   input  logic                  conv_drdy,
   input  logic [DATA_WIDTH-1:0] conv_data,
   output logic                  avg_valid,
   output logic [DATA_WIDTH-1:0] avg_data,
   output logic                  busy,
   output logic                  err_timeout,
   output logic                  overrun,
   output logic [1:0]            led
);

   localparam int AW = DATA_WIDTH + SAMPLES_LOG2;
   localparam int CW = SAMPLES_LOG2 + 1;
   localparam int TW = $clog2(TIMEOUT_CLOCKS);
   localparam logic [CW-1:0] CNT_LAST =
      CW'((1 << SAMPLES_LOG2) - 1);
   localparam logic [TW-1:0] TMO_LAST =
      TW'(TIMEOUT_CLOCKS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  acq_prev_q, acq_prev_d;
   logic [AW-1:0]         acc_q, acc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  avg_valid_q, avg_valid_d;
   logic [DATA_WIDTH-1:0] avg_data_q, avg_data_d;
   logic                  err_q, err_d;
   logic                  ovr_q, ovr_d;

   logic                  trig;
   logic [AW-1:0]         acc_sum;

   always_comb begin
      trig        = acq_timing & ~acq_prev_q;
      acc_sum     = acc_q + AW'(conv_data);
      state_d     = state_q;
      acq_prev_d  = acq_timing;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      avg_valid_d = 1'b0;
      avg_data_d  = avg_data_q;
      err_d       = 1'b0;
      // edges arriving outside IDLE are lost and remembered
      ovr_d       = ovr_q | (trig & (state_q != S_IDLE));
      unique case (1'b1)
         (state_q == S_IDLE): begin
            if (trig) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         (state_q == S_REQ): begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         (state_q == S_WAIT): begin
            tmo_d = tmo_q + TW'(1);
            if (conv_drdy) begin
               acc_d = acc_sum;
               if (cnt_q == CNT_LAST) begin
                  avg_data_d  =
                     DATA_WIDTH'(acc_sum >> SAMPLES_LOG2);
                  avg_valid_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  state_d = S_REQ;
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_100M) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acq_prev_q  <= 1'b1;
         acc_q       <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         avg_valid_q <= 1'b0;
         avg_data_q  <= '0;
         err_q       <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acq_prev_q  <= acq_prev_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         avg_valid_q <= avg_valid_d;
         avg_data_q  <= avg_data_d;
         err_q       <= err_d;
         ovr_q       <= ovr_d;
      end
   end

   assign conv_start  = (state_q == S_REQ);
   assign busy        = (state_q != S_IDLE);
   assign led         = state_q;
   assign avg_valid   = avg_valid_q;
   assign avg_data    = avg_data_q;
   assign err_timeout = err_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_ad_acq_sequencer.sv
// Bench for ad_acq_sequencer: table-driven bursts with a scoreboard
// of expected averages, plus timeout, overrun and reset sequences.
module tb_ad_acq_sequencer;

   logic        clk_100M = 1'b0;
   logic        rst;
   logic        acq_timing;
   logic        conv_start;
   logic        conv_drdy;
   logic [15:0] conv_data;
   logic        avg_valid;
   logic [15:0] avg_data;
   logic        busy;
   logic        err_timeout;
   logic        overrun;
   logic [1:0]  led;

   ad_acq_sequencer #(
      .DATA_WIDTH(16),
      .SAMPLES_LOG2(2),
      .TIMEOUT_CLOCKS(200)
   ) dut (
      .clk_100M(clk_100M),
      .rst(rst),
      .acq_timing(acq_timing),
      .conv_start(conv_start),
      .conv_drdy(conv_drdy),
      .conv_data(conv_data),
      .avg_valid(avg_valid),
      .avg_data(avg_data),
      .busy(busy),
      .err_timeout(err_timeout),
      .overrun(overrun),
      .led(led)
   );

   always #5 clk_100M = ~clk_100M;

   typedef struct {
      logic [3:0][15:0] d;
      int               lat;
      logic [15:0]      exp_avg;
   } vec_t;

   vec_t        vecs [6];
   logic [15:0] sb [$];
   int          nchk  = 0;
   int          nfail = 0;
   int          cs_cnt = 0;
   logic        err_ok = 1'b0;
   logic        pv_cs = 1'b0;
   logic        pv_av = 1'b0;
   logic        pv_er = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_100M);
   endtask

   // Output monitor: scoreboard pops and single-cycle pulse rules
   always @(negedge clk_100M) begin
      if (conv_start) cs_cnt++;
      if (avg_valid) begin
         if (sb.size() == 0) chk("unexpected_avg", 1, 0);
         else chk("sb_avg", avg_data, sb.pop_front());
      end
      if (err_timeout && !err_ok) chk("unexpected_err", 1, 0);
      if (conv_start && pv_cs) chk("cs_back2back", 1, 0);
      if (avg_valid && pv_av) chk("av_back2back", 1, 0);
      if (err_timeout && pv_er) chk("err_back2back", 1, 0);
      pv_cs = conv_start;
      pv_av = avg_valid;
      pv_er = err_timeout;
   end

   task automatic do_burst(input logic [3:0][15:0] d, input int lat,
                           input logic [15:0] ex, input int ovr);
      int cs0;
      sb.push_back(ex);
      cs0 = cs_cnt;
      acq_timing = 1'b1;
      tick();
      acq_timing = 1'b0;
      for (int s = 0; s < 4; s++) begin
         chk("conv_start", conv_start, 1);
         chk("busy_req", busy, 1);
         tick();
         for (int w = 0; w < lat; w++) tick();
         conv_drdy = 1'b1;
         conv_data = d[s];
         if (s == ovr) acq_timing = 1'b1;
         tick();
         conv_drdy  = 1'b0;
         acq_timing = 1'b0;
      end
      chk("avg_valid_at", avg_valid, 1);
      chk("avg_data_at", avg_data, ex);
      chk("busy_end", busy, 0);
      chk("n_conv_start", cs_cnt - cs0, 4);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      vecs[0] = '{{16'd103, 16'd102, 16'd101, 16'd100}, 0, 16'd101};
      vecs[1] = '{{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0,
                  16'hFFFF};
      vecs[2] = '{{16'd3, 16'd0, 16'd0, 16'd0}, 2, 16'd0};
      vecs[3] = '{{16'd5, 16'd3, 16'd2, 16'd1}, 3, 16'd2};
      vecs[4] = '{{16'h0001, 16'h7FFF, 16'h8000, 16'h8000}, 1,
                  16'h6000};
      vecs[5] = '{{16'd40, 16'd30, 16'd20, 16'd10}, 199, 16'd25};

      rst        = 1'b1;
      acq_timing = 1'b0;
      conv_drdy  = 1'b0;
      conv_data  = '0;
      tick();
      tick();
      chk("rst_conv_start", conv_start, 0);
      chk("rst_avg_valid", avg_valid, 0);
      chk("rst_avg_data", avg_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_led", led, 0);
      rst = 1'b0;
      tick();
      tick();

      for (int i = 0; i < 6; i++)
         do_burst(vecs[i].d, vecs[i].lat, vecs[i].exp_avg, -1);
      chk("no_overrun_yet", overrun, 0);

      // silent reader: abort after TIMEOUT_CLOCKS in WAIT
      err_ok     = 1'b1;
      acq_timing = 1'b1;
      tick();
      acq_timing = 1'b0;
      n = 1;
      while (!err_timeout && n < 400) begin
         tick();
         n++;
      end
      chk("tmo_latency", n, 202);
      chk("tmo_err", err_timeout, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_avg_valid", avg_valid, 0);
      chk("tmo_avg_hold", avg_data, 16'd25);
      tick();
      err_ok = 1'b0;
      chk("tmo_err_cleared", err_timeout, 0);
      do_burst(vecs[0].d, 0, 16'd101, -1);

      // stray strobes in IDLE must not leak into the next average
      for (int i = 0; i < 3; i++) begin
         conv_drdy = 1'b1;
         conv_data = 16'hFFFF;
         tick();
      end
      conv_drdy = 1'b0;
      tick();
      chk("idle_drdy_busy", busy, 0);
      do_burst(vecs[3].d, 0, 16'd2, -1);

      do_burst(vecs[0].d, 0, 16'd101, 2);
      chk("overrun_set", overrun, 1);
      do_burst(vecs[4].d, 0, 16'h6000, -1);
      chk("overrun_sticky", overrun, 1);

      // reset during the third WAIT with acq_timing held high
      acq_timing = 1'b1;
      tick();
      for (int s = 0; s < 2; s++) begin
         tick();
         conv_drdy = 1'b1;
         conv_data = 16'd50;
         tick();
         conv_drdy = 1'b0;
      end
      tick();
      chk("mid_wait_led", led, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_conv_start", conv_start, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_avg_valid", avg_valid, 0);
      chk("mrst_err", err_timeout, 0);
      chk("mrst_overrun", overrun, 0);
      chk("mrst_avg_data", avg_data, 0);
      chk("mrst_led", led, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("held_high_no_trig", busy, 0);
      acq_timing = 1'b0;
      tick();
      do_burst(vecs[2].d, 0, 16'd0, -1);
      do_burst(vecs[0].d, 0, 16'd101, -1);

      tick();
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
